// File: rtl/bcd_display.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a 3-digit
// multiplexed common-anode 7-segment display with optional leading-zero blanking.
module bcd_display #(
  parameter int REFRESH_DIV = 50000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic [7:0]  bin,
  output logic [11:0] bcd,
  output logic        done,
  output logic        busy,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  // state | meaning
  // IDLE  | waiting for init; bcd holds last result
  // ADD3  | add 3 to every BCD field >= 5
  // SHIFT | shift register left by one, decrement iteration count
  // FIN   | publish result, pulse done
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ADD3  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [1:0]    state;
  logic [19:0]   sr;
  logic [19:0]   sr_adj;
  logic [3:0]    count;
  logic [RW-1:0] refresh;
  logic [1:0]    digit;
  logic [3:0]    digit_val;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign sr_adj = {add3(sr[19:16]), add3(sr[15:12]), add3(sr[11:8]), sr[7:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sr    <= '0;
      count <= '0;
      bcd   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            sr    <= {12'b0, bin};
            count <= 4'd8;
            busy  <= 1'b1;
            state <= ADD3;
          end
        end
        ADD3: begin
          sr    <= sr_adj;
          state <= SHIFT;
        end
        SHIFT: begin
          sr    <= {sr[18:0], 1'b0};
          count <= count - 4'd1;
          // count is about to become zero: that was the eighth shift
          state <= (count == 4'd1) ? FIN : ADD3;
        end
        FIN: begin
          bcd   <= sr[19:8];
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan runs free of the conversion FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
      digit   <= 2'd0;
    end else if (refresh == RW'(REFRESH_DIV - 1)) begin
      refresh <= '0;
      digit   <= (digit == 2'd2) ? 2'd0 : digit + 2'd1;
    end else begin
      refresh <= refresh + RW'(1);
    end
  end

  always_comb begin
    an        = 3'b110;
    digit_val = bcd[3:0];
    blank     = 1'b0;
    case (digit)
      2'd1: begin
        an        = 3'b101;
        digit_val = bcd[7:4];
        blank     = BLANK_LZ && (bcd[11:4] == 8'd0);
      end
      2'd2: begin
        an        = 3'b011;
        digit_val = bcd[11:8];
        blank     = BLANK_LZ && (bcd[11:8] == 4'd0);
      end
      default: begin
        an        = 3'b110;
        digit_val = bcd[3:0];
        blank     = 1'b0;
      end
    endcase
    seg = blank ? 7'b1111111 : seg_code(digit_val);
  end

endmodule

// File: tb/tb_bcd_display.sv
// Scoreboard bench for bcd_display: two instances (blanking on/off) share stimulus;
// expected BCD is queued at each accepted start and popped on every done pulse.
module tb_bcd_display;
  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init = 1'b0;
  logic [7:0]  bin = 8'd0;
  logic [11:0] bcd, bcd_nb;
  logic        done, done_nb, busy, busy_nb;
  logic [6:0]  seg, seg_nb;
  logic [2:0]  an, an_nb;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [11:0] exp_q[$];
  logic [11:0] mon_exp;

  always #5 clk = ~clk;

  bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .rst(rst), .init(init), .bin(bin), .bcd(bcd), .done(done),
    .busy(busy), .seg(seg), .an(an)
  );

  bcd_display #(.REFRESH_DIV(DIV), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .init(init), .bin(bin), .bcd(bcd_nb), .done(done_nb),
    .busy(busy_nb), .seg(seg_nb), .an(an_nb)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] lut(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0: s = 7'b1000000; 4'd1: s = 7'b1111001; 4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000; 4'd4: s = 7'b0011001; 4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010; 4'd7: s = 7'b1111000; 4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000; default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  function automatic logic [6:0] exp_seg(input logic [11:0] v, input int d, input bit blz);
    logic [3:0] h, t, u;
    h = v[11:8]; t = v[7:4]; u = v[3:0];
    if (d == 0) return lut(u);
    if (d == 1) return (blz && h == 4'd0 && t == 4'd0) ? 7'b1111111 : lut(t);
    return (blz && h == 4'd0) ? 7'b1111111 : lut(h);
  endfunction

  function automatic logic [2:0] an_of(input int d);
    return (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("bcd", 32'(bcd), 32'(mon_exp));
        chk("bcd_nb", 32'(bcd_nb), 32'(mon_exp));
      end
    end
  end

  task automatic wait_done(output int busy_cyc);
    busy_cyc = 0;
    for (int i = 0; i < 40 && !done; i++) begin
      if (busy) busy_cyc++;
      @(negedge clk);
    end
    chk("done_seen", 32'(done), 32'd1);
  endtask

  task automatic convert(input int v, output int busy_cyc);
    @(negedge clk);
    bin = 8'(v);
    init = 1'b1;
    exp_q.push_back(to_bcd(v));
    @(negedge clk);
    init = 1'b0;
    wait_done(busy_cyc);
    @(negedge clk);
    chk("done_width", 32'(done), 32'd0);
  endtask

  task automatic check_digits(input logic [11:0] v, input string tag);
    int n;
    for (int d = 0; d < 3; d++) begin
      n = 0;
      while (an !== an_of(d) && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_an"}, 32'(an), 32'(an_of(d)));
      chk({tag, "_an_nb"}, 32'(an_nb), 32'(an_of(d)));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg(v, d, 1'b1)));
      chk({tag, "_seg_nb"}, 32'(seg_nb), 32'(exp_seg(v, d, 1'b0)));
    end
  endtask

  task automatic check_scan_steps(input logic [11:0] v);
    logic [2:0] prev;
    int n, i0, idx;
    prev = an;
    n = 0;
    while (an === prev && n < 20) begin
      @(negedge clk);
      n++;
    end
    i0 = (an === 3'b110) ? 0 : (an === 3'b101) ? 1 : 2;
    chk("scan_phase_valid", 32'(an), 32'(an_of(i0)));
    for (int k = 0; k < 12; k++) begin
      idx = (i0 + k / DIV) % 3;
      chk("scan_an", 32'(an), 32'(an_of(idx)));
      chk("scan_seg", 32'(seg), 32'(exp_seg(v, idx, 1'b1)));
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, saved;

    rst = 1'b0; init = 1'b1; bin = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_an", 32'(an), 32'(3'b110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    init = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("scan_start_an", 32'(an), 32'(3'b110));

    convert(255, bc);
    chk("busy_cycles_255", 32'(bc), 32'd17);
    check_digits(12'h255, "d255");

    convert(0, bc);
    chk("busy_cycles_0", 32'(bc), 32'd17);
    check_digits(12'h000, "d000");

    // init pulses during a conversion are dropped; one right after FIN is taken
    saved = done_cnt;
    @(negedge clk);
    bin = 8'd100; init = 1'b1;
    exp_q.push_back(to_bcd(100));
    @(negedge clk);
    init = 1'b0; bin = 8'd37;
    repeat (4) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (11) @(negedge clk);
    init = 1'b1;
    @(negedge clk);
    chk("ignore_done_e17", 32'(done), 32'd1);
    chk("ignore_busy_e17", 32'(busy), 32'd0);
    chk("ignore_bcd_e17", 32'(bcd), 32'h100);
    exp_q.push_back(to_bcd(37));
    @(negedge clk);
    init = 1'b0;
    chk("e18_busy", 32'(busy), 32'd1);
    wait_done(bc);
    @(negedge clk);
    chk("ignore_done_count", 32'(done_cnt - saved), 32'd2);
    check_digits(12'h037, "d037");

    // abort mid-conversion
    @(negedge clk);
    bin = 8'd200; init = 1'b1;
    @(negedge clk);
    init = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    saved = done_cnt;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(saved));
    chk("abort_bcd_hold", 32'(bcd), 32'h0);
    convert(45, bc);
    chk("busy_cycles_45", 32'(bc), 32'd17);

    convert(105, bc);
    check_scan_steps(12'h105);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
